pwm_multi_gen: RTL
==================

# pwm_multi_gen

Multi-channel, parametrised PWM generator: one shared free-running period counter drives CHANNELS independent comparator channels. Each channel has its own compare values, alignment mode and output polarity. All configuration is double-buffered, with shadow registers committed at the period boundary, so duty-cycle updates never produce glitched pulses. The block sits between the register/config interface and the PWM output pins. It replaces the single-channel generator that needed an external counter.

## Interface

Parameters:
- WIDTH, 16, width of counter, period and compare values
- CHANNELS, 4, number of PWM output channels (1..16)
- CH_W, $clog2(CHANNELS) (min 1), width of channel select

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- pwm_en  in  1  global enable; 0 holds the counter and forces outputs low
- cfg_wr  in  1  config write strobe, single-cycle, no backpressure
- cfg_ch  in  CH_W  target channel; ignored for PERIOD writes; values >= CHANNELS are dropped
- cfg_sel  in  2  field select: 0 CMP1, 1 CMP2, 2 CTRL, 3 PERIOD
- cfg_data  in  WIDTH  write data; CTRL uses bits [1:0]=mode, [2]=polarity
- count_val  out  WIDTH  registered shared counter value
- period_wrap  out  1  one-cycle pulse, high while count_val==0 following a wrap
- pwm_out  out  CHANNELS  registered PWM outputs

## Operation

- **Period:** active period P counts 0..P-1. P=0 is treated as P=1 (counter stays 0 and wraps every cycle).
- **Counter:**
  - pwm_en=1: if count_val==P-1, next value is 0 (a wrap); otherwise count_val+1.
  - pwm_en=0: count_val <= 0.
- **Commit event:** a wrap, or any cycle with pwm_en=0. On a commit event, active period and all channels' active CMP1/CMP2/CTRL load from shadow.
- **Config writes:** a cfg_wr always updates the shadow field. If the write coincides with a commit event, the written value is committed (write-through bypass).
- **Per-channel raw level r (c = count_val, compares unsigned):**
  - mode 00 LEFT: r = c < CMP1
  - mode 01 RIGHT: r = c >= CMP1
  - mode 10 RANGE: r = CMP1 <= c < CMP2; if CMP1 >= CMP2, always low
  - mode 11 NOTCH: r = !(CMP1 <= c < CMP2)
- **Output:** pwm_out[i] <= pwm_en ? (r ^ polarity) : 0. A disabled block drives 0 regardless of polarity.
- **Compare boundaries:**
  - CMP1 >= P: LEFT is 100% high, RIGHT is 0%.
  - CMP1=0: LEFT is 0%, RIGHT is 100%.
- **Reset (applies at any time, including mid-period):** count_val=0, period_wrap=0, pwm_out=0, and all shadow and active registers = 0 (P=0, CMP=0, mode LEFT, polarity 0). Pending shadow writes are discarded.

## Timing

- pwm_out[i] in cycle n+1 reflects count_val and active config in cycle n (one-cycle latency).
- **Enable:**
  - First edge with pwm_en=1: count_val goes 0→1 and pwm_out takes its count-0 value.
  - pwm_en falling: at the next edge count_val=0 and pwm_out=0.
- **period_wrap:** registered; high in exactly the cycle where count_val returns to 0 from P-1. It is not asserted on the enable-start 0.
- **Config latency:** a write at cycle n takes effect on the output no earlier than the first commit at or after n. The old duty cycle completes its period unchanged.
- **Throughput:** a new config write is accepted every cycle. Multiple writes to one field before a commit: the last write wins.

## Structure

- **Package pwm_pkg:**
  - mode constants PWM_LEFT=2'b00, PWM_RIGHT=2'b01, PWM_RANGE=2'b10, PWM_NOTCH=2'b11
  - cfg_sel constants SEL_CMP1/SEL_CMP2/SEL_CTRL/SEL_PERIOD
  - CTRL bit positions
- **Sub-module pwm_chan:** one channel.
  - Contains the shadow and active CMP1/CMP2/CTRL registers, the comparator and the output flop.
  - Instantiated CHANNELS times in a generate loop.
  - Receives count_val, commit, a decoded write enable and pwm_en.
- **Top level:** counter, period shadow/active registers, commit generation, cfg_ch decode.

## Test plan

- LEFT: period=10, ch0 CMP1=4, enable → pwm_out[0] high 4 of every 10 cycles, first high one cycle after enable; period_wrap every 10 cycles.
- RIGHT, RANGE and NOTCH concurrently: period=10; ch1 RIGHT CMP1=3; ch2 RANGE 3/7; ch3 NOTCH 3/7 → required high counts:
  - ch1 high for counts 3..9 (7 cycles)
  - ch2 high for counts 3..6
  - ch3 high for counts 0..2 and 7..9
- Polarity and boundaries: ch0 LEFT CMP1=12 with period=10 → always high; set polarity=1 → always low; CMP1=0 → always high with polarity=1.
- Shadow update: ch0 LEFT CMP1=4, write CMP1=8 at count 2 → current period keeps 4 high cycles, next period 8; write landing on the wrap cycle applies to the very next period.
- Disable and reset mid-period:
  - pwm_en=0 at count 5 → next cycle count_val=0, pwm_out=0; re-enable restarts from count 0.
  - rst_n=0 at count 6 → all outputs 0 and config cleared; after release with pwm_en=1, P=0 holds count_val=0 with period_wrap high every cycle.
- Invalid channel: cfg_ch=CHANNELS (non-power-of-2 CHANNELS=3) write → no channel changes.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
//   - channel alignment modes and config field selects
//   - CTRL word bit positions and a decoder for it
package pwm_pkg;

  typedef enum logic [1:0] {
    PWM_LEFT  = 2'b00,
    PWM_RIGHT = 2'b01,
    PWM_RANGE = 2'b10,
    PWM_NOTCH = 2'b11
  } pwm_mode_e;

  typedef enum logic [1:0] {
    SEL_CMP1   = 2'd0,
    SEL_CMP2   = 2'd1,
    SEL_CTRL   = 2'd2,
    SEL_PERIOD = 2'd3
  } cfg_sel_e;

  localparam int unsigned CTRL_MODE_LSB = 0;
  localparam int unsigned CTRL_MODE_MSB = 1;
  localparam int unsigned CTRL_POL_BIT  = 2;
  localparam int unsigned CTRL_BITS     = 3;

  typedef struct packed {
    logic      pol;
    pwm_mode_e mode;
  } pwm_ctrl_t;

  function automatic pwm_ctrl_t decode_ctrl(input logic [CTRL_BITS-1:0] bits);
    pwm_ctrl_t c;
    c.mode = pwm_mode_e'(bits[CTRL_MODE_MSB:CTRL_MODE_LSB]);
    c.pol  = bits[CTRL_POL_BIT];
    return c;
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: shadow and active CMP1/CMP2/CTRL registers, the
// comparator against the shared counter and the registered output.
//   clk_i     system clock
//   rst_ni    synchronous active-low reset
//   pwm_en_i  global enable (0 forces the output low)
//   commit_i  load active config from shadow this cycle
//   wr_i      decoded config write for this channel
//   sel_i     field select (CMP1/CMP2/CTRL)
//   data_i    write data
//   count_i   shared period counter value
//   pwm_o     registered PWM output
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pwm_en_i,
  input  logic             commit_i,
  input  logic             wr_i,
  input  cfg_sel_e         sel_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             pwm_o
);

  logic [WIDTH-1:0] cmp1_sh_q, cmp1_sh_d;
  logic [WIDTH-1:0] cmp2_sh_q, cmp2_sh_d;
  pwm_ctrl_t        ctrl_sh_q, ctrl_sh_d;
  logic [WIDTH-1:0] cmp1_act_q, cmp1_act_d;
  logic [WIDTH-1:0] cmp2_act_q, cmp2_act_d;
  pwm_ctrl_t        ctrl_act_q, ctrl_act_d;
  logic             pwm_q, pwm_d;

  logic at_or_above1;
  logic below2;
  logic in_window;
  logic raw;

  always_comb begin
    cmp1_sh_d = cmp1_sh_q;
    cmp2_sh_d = cmp2_sh_q;
    ctrl_sh_d = ctrl_sh_q;
    if (wr_i) begin
      case (sel_i)
        SEL_CMP1: cmp1_sh_d = data_i;
        SEL_CMP2: cmp2_sh_d = data_i;
        SEL_CTRL: ctrl_sh_d = decode_ctrl(data_i[CTRL_BITS-1:0]);
        default:  ;
      endcase
    end

    // Active loads from the post-write shadow value, so a write landing
    // on a commit cycle takes effect immediately.
    cmp1_act_d = commit_i ? cmp1_sh_d : cmp1_act_q;
    cmp2_act_d = commit_i ? cmp2_sh_d : cmp2_act_q;
    ctrl_act_d = commit_i ? ctrl_sh_d : ctrl_act_q;
  end

  always_comb begin
    at_or_above1 = (count_i >= cmp1_act_q);
    below2       = (count_i < cmp2_act_q);
    // Empty when CMP1 >= CMP2: no count can satisfy both bounds.
    in_window    = at_or_above1 && below2;
    raw          = 1'b0;
    case (ctrl_act_q.mode)
      PWM_LEFT:  raw = !at_or_above1;
      PWM_RIGHT: raw = at_or_above1;
      PWM_RANGE: raw = in_window;
      PWM_NOTCH: raw = !in_window;
      default:   raw = 1'b0;
    endcase
    pwm_d = pwm_en_i & (raw ^ ctrl_act_q.pol);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cmp1_sh_q  <= '0;
      cmp2_sh_q  <= '0;
      ctrl_sh_q  <= '0;
      cmp1_act_q <= '0;
      cmp2_act_q <= '0;
      ctrl_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      cmp1_sh_q  <= cmp1_sh_d;
      cmp2_sh_q  <= cmp2_sh_d;
      ctrl_sh_q  <= ctrl_sh_d;
      cmp1_act_q <= cmp1_act_d;
      cmp2_act_q <= cmp2_act_d;
      ctrl_act_q <= ctrl_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator with a shared free-running period counter
// and double-buffered per-channel configuration.
//   clk          system clock
//   rst_n        synchronous active-low reset
//   pwm_en       global enable; 0 holds counter at 0, outputs low
//   cfg_wr       single-cycle config write strobe
//   cfg_ch       target channel (ignored for PERIOD, >= CHANNELS dropped)
//   cfg_sel      field select: CMP1, CMP2, CTRL, PERIOD
//   cfg_data     write data
//   count_val    registered counter value
//   period_wrap  one-cycle pulse while count_val is 0 after a wrap
//   pwm_out      registered PWM outputs
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwm_en,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_sel,
  input  logic [WIDTH-1:0]    cfg_data,
  output logic [WIDTH-1:0]    count_val,
  output logic                period_wrap,
  output logic [CHANNELS-1:0] pwm_out
);

  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    period_sh_q, period_sh_d;
  logic [WIDTH-1:0]    period_act_q, period_act_d;
  logic                wrap_q, wrap_d;
  logic [WIDTH-1:0]    last_cnt;
  logic                wrap_now;
  logic                commit;
  cfg_sel_e            sel;
  logic [CHANNELS-1:0] ch_wr;
  logic [CHANNELS-1:0] chan_pwm;

  assign sel = cfg_sel_e'(cfg_sel);

  always_comb begin
    // P=0 behaves as P=1: the last count is 0 and every cycle wraps.
    last_cnt = (period_act_q == '0) ? '0 : period_act_q - WIDTH'(1);
    wrap_now = pwm_en && (count_q == last_cnt);
    commit   = !pwm_en || wrap_now;

    count_d = '0;
    if (pwm_en) begin
      count_d = wrap_now ? '0 : count_q + WIDTH'(1);
    end
    wrap_d = wrap_now;

    period_sh_d = period_sh_q;
    if (cfg_wr && (sel == SEL_PERIOD)) begin
      period_sh_d = cfg_data;
    end
    period_act_d = commit ? period_sh_d : period_act_q;
  end

  // Channel select never matches an index >= CHANNELS, so such writes drop.
  always_comb begin
    ch_wr = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cfg_wr && (sel != SEL_PERIOD) && (cfg_ch == CH_W'(i))) begin
        ch_wr[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q      <= '0;
      period_sh_q  <= '0;
      period_act_q <= '0;
      wrap_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      wrap_q       <= wrap_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pwm_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .pwm_en_i (pwm_en),
      .commit_i (commit),
      .wr_i     (ch_wr[g]),
      .sel_i    (sel),
      .data_i   (cfg_data),
      .count_i  (count_q),
      .pwm_o    (chan_pwm[g])
    );
  end

  assign count_val   = count_q;
  assign period_wrap = wrap_q;
  assign pwm_out     = chan_pwm;

endmodule
